// File: rtl/im_loader_if.sv
// Byte-stream loader bus: stream handshake in, instruction-memory write port
// and status out. master drives the stream, slave is the loader.
`timescale 1ns/1ps

interface im_loader_if;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        im_WE;
    logic [31:0] im_DATA;
    logic [31:0] im_ADDR;
    logic        core_RESET;
    logic        busy;
    logic        done;
    logic [1:0]  error;

    modport master (
        output start, in_valid, in_byte,
        input  in_ready, im_WE, im_DATA, im_ADDR, core_RESET, busy, done, error
    );

    modport slave (
        input  start, in_valid, in_byte,
        output in_ready, im_WE, im_DATA, im_ADDR, core_RESET, busy, done, error
    );
endinterface

// File: rtl/im_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory
// one 32-bit word at a time, and holds the core in reset until a verified load.
`timescale 1ns/1ps

module im_loader #(
    parameter int MAX_WORDS = 1024
) (
    input logic        clk,
    input logic        rst_n,
    im_loader_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, HDR0, HDR1, DATA, WRITE, CSUM, DONE, ERR
    } state_t;

    localparam logic [1:0]  ERR_NONE = 2'b00;
    localparam logic [1:0]  ERR_LEN  = 2'b01;
    localparam logic [1:0]  ERR_CSUM = 2'b10;
    localparam logic [16:0] MAX_N    = 17'(MAX_WORDS);

    state_t      state, state_nx;
    logic [15:0] n;
    logic [15:0] idx;
    logic [1:0]  byte_cnt;
    logic [7:0]  acc;
    logic [23:0] word;
    logic [31:0] wr_data;
    logic [31:0] wr_addr;
    logic        done_q;
    logic [1:0]  err_q;

    logic        xfer;
    logic [16:0] hdr_n;
    logic        hdr_bad;
    logic        last_word;
    logic        csum_ok;

    assign xfer      = bus.in_valid && bus.in_ready;
    assign hdr_n     = {1'b0, bus.in_byte, n[7:0]};
    assign hdr_bad   = (hdr_n == 17'd0) || (hdr_n > MAX_N);
    assign last_word = (17'(idx) + 17'd1) == {1'b0, n};
    assign csum_ok   = bus.in_byte == acc;

    assign bus.im_DATA = wr_data;
    assign bus.im_ADDR = wr_addr;
    assign bus.done    = done_q;
    assign bus.error   = err_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE, ERR: if (bus.start) state_nx = HDR0;
            HDR0:            if (xfer) state_nx = HDR1;
            HDR1:            if (xfer) state_nx = hdr_bad ? ERR : DATA;
            DATA:            if (xfer && byte_cnt == 2'd3) state_nx = WRITE;
            WRITE:           state_nx = last_word ? CSUM : DATA;
            CSUM:            if (xfer) state_nx = csum_ok ? DONE : ERR;
            default:         state_nx = IDLE;
        endcase
    end

    // Status outputs are decoded from state, so reset forces them at once.
    always_comb begin
        bus.in_ready   = 1'b0;
        bus.busy       = 1'b0;
        bus.im_WE      = 1'b0;
        bus.core_RESET = 1'b1;
        case (state)
            HDR0, HDR1, DATA, CSUM: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b1;
            end
            WRITE: begin
                bus.busy  = 1'b1;
                bus.im_WE = 1'b1;
            end
            DONE:    bus.core_RESET = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n        <= '0;
            idx      <= '0;
            byte_cnt <= '0;
            acc      <= '0;
            word     <= '0;
            wr_data  <= '0;
            wr_addr  <= '0;
            done_q   <= 1'b0;
            err_q    <= ERR_NONE;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (bus.start) begin
                        idx      <= '0;
                        byte_cnt <= '0;
                        acc      <= '0;
                        done_q   <= 1'b0;
                        err_q    <= ERR_NONE;
                    end
                end
                HDR0: if (xfer) n[7:0] <= bus.in_byte;
                HDR1: begin
                    if (xfer) begin
                        n[15:8] <= bus.in_byte;
                        if (hdr_bad) err_q <= ERR_LEN;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        acc      <= acc ^ bus.in_byte;
                        byte_cnt <= byte_cnt + 2'd1;
                        // The last byte goes straight into the write register so
                        // the word is presented in the very next cycle.
                        unique case (byte_cnt)
                            2'd0: word[7:0]   <= bus.in_byte;
                            2'd1: word[15:8]  <= bus.in_byte;
                            2'd2: word[23:16] <= bus.in_byte;
                            2'd3: begin
                                wr_data <= {bus.in_byte, word};
                                wr_addr <= {16'd0, idx};
                            end
                        endcase
                    end
                end
                WRITE: idx <= idx + 16'd1;
                CSUM: begin
                    if (xfer) begin
                        if (csum_ok) done_q <= 1'b1;
                        else         err_q  <= ERR_CSUM;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
